// File: rtl/shm_pkg.sv
// Shared types and widths for the shared-memory DMA front end.
package shm_pkg;

  localparam int unsigned PROCSIZE    = 4;
  localparam int unsigned SIZE        = 4;
  localparam int unsigned WORD_SIZE   = 8;
  localparam int unsigned PAGE_SIZE   = 2;
  localparam int unsigned PAGES_COUNT = SIZE - PAGE_SIZE;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, ACK} sched_state_t;

  // Descriptor snapshot handed to the engine
  typedef struct packed {
    logic                action;
    logic [SIZE-1:0]     ptr;
    logic [PROCSIZE-1:0] copy_start;
    logic [PROCSIZE-1:0] copy_length;
  } desc_t;

endpackage

// File: rtl/shm_dma_scheduler_if.sv
// Scheduler <-> DMA engine descriptor handshake and completion report.
interface shm_dma_scheduler_if #(parameter int unsigned PROC_CNT = 4);
  import shm_pkg::*;

  localparam int unsigned PIDX_W = $clog2(PROC_CNT);

  logic                   eng_valid;
  logic                   eng_ready;
  logic [PIDX_W-1:0]      eng_proc;
  logic                   eng_action;
  logic [SIZE-1:0]        eng_ptr;
  logic [PROCSIZE-1:0]    eng_copy_start;
  logic [PROCSIZE-1:0]    eng_copy_length;
  logic                   eng_done;
  logic [PAGES_COUNT-1:0] eng_page;

  modport master (
    output eng_valid, eng_proc, eng_action, eng_ptr, eng_copy_start, eng_copy_length,
    input  eng_ready, eng_done, eng_page
  );

  modport slave (
    input  eng_valid, eng_proc, eng_action, eng_ptr, eng_copy_start, eng_copy_length,
    output eng_ready, eng_done, eng_page
  );

endinterface

// File: rtl/shm_dma_scheduler_picker.sv
// Combinational round-robin picker: first pending index after 'last', wrapping.
module rr_priority_picker #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         pending,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] grant,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] idx;

  // Scan farthest-first so the nearest pending slot after 'last' wins
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |pending;
    for (int k = int'(N); k >= 1; k--) begin
      idx = IW'((int'(last) + k) % int'(N));
      if (pending[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/shm_dma_scheduler.sv
// Round-robin request sequencer for the shared-memory DMA engine (one descriptor in flight).
module shm_dma_scheduler
  import shm_pkg::*;
#(
  parameter int unsigned PROC_CNT = 4
) (
  input  logic                   clock,
  input  logic                   start,
  input  logic [PROC_CNT-1:0]    trigger,
  input  logic [PROC_CNT-1:0]    action,
  input  logic [SIZE-1:0]        ptr         [PROC_CNT],
  input  logic [PROCSIZE-1:0]    copy_start  [PROC_CNT],
  input  logic [PROCSIZE-1:0]    copy_length [PROC_CNT],
  output logic [PROC_CNT-1:0]    ack,
  output logic [PAGES_COUNT-1:0] ptr_out     [PROC_CNT],
  shm_dma_scheduler_if.master    eng,
  output logic                   proto_err
);

  localparam int unsigned PIDX_W = $clog2(PROC_CNT);

  sched_state_t           state_q, state_d;
  desc_t                  desc_q, desc_d;
  logic [PIDX_W-1:0]      proc_q, proc_d;
  logic [PIDX_W-1:0]      last_q, last_d;
  logic [PROC_CNT-1:0]    seen_q, seen_d;
  logic [PROC_CNT-1:0]    ack_q, ack_d;
  logic [PAGES_COUNT-1:0] ptr_out_q [PROC_CNT];
  logic [PAGES_COUNT-1:0] ptr_out_d [PROC_CNT];
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic [PROC_CNT-1:0]    pending;
  logic [PIDX_W-1:0]      grant;
  logic                   any;

  assign pending = trigger ^ seen_q;

  rr_priority_picker #(.N(PROC_CNT)) u_picker (
    .pending (pending),
    .last    (last_q),
    .grant   (grant),
    .any     (any)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    desc_d    = desc_q;
    proc_d    = proc_q;
    last_d    = last_q;
    seen_d    = seen_q;
    ack_d     = ack_q;
    ptr_out_d = ptr_out_q;
    valid_d   = valid_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (any) begin
          proc_d             = grant;
          last_d             = grant;
          seen_d[grant]      = trigger[grant];
          desc_d.action      = action[grant];
          desc_d.ptr         = ptr[grant];
          desc_d.copy_start  = copy_start[grant];
          desc_d.copy_length = copy_length[grant];
          // Zero-length requests complete without involving the engine
          if (copy_length[grant] == '0) begin
            state_d = ACK;
          end else begin
            state_d = ISSUE;
            valid_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (eng.eng_ready) begin
          valid_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (eng.eng_done) begin
          if (desc_q.action == WRITE) ptr_out_d[proc_q] = eng.eng_page;
          state_d = ACK;
        end
      end
      ACK: begin
        ack_d[proc_q] = ~ack_q[proc_q];
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Sticky protocol checks; they never alter sequencing
    if ((state_q != IDLE) && pending[proc_q]) err_d = 1'b1;
    if (eng.eng_done  && (state_q != BUSY))   err_d = 1'b1;
    if (eng.eng_ready && (state_q != ISSUE))  err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (start) begin
      state_q <= IDLE;
      desc_q  <= '0;
      proc_q  <= '0;
      last_q  <= PIDX_W'(PROC_CNT - 1);
      seen_q  <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(PROC_CNT); i++) ptr_out_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      desc_q    <= desc_d;
      proc_q    <= proc_d;
      last_q    <= last_d;
      seen_q    <= seen_d;
      ack_q     <= ack_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      ptr_out_q <= ptr_out_d;
    end
  end

  assign ack                 = ack_q;
  assign ptr_out             = ptr_out_q;
  assign proto_err           = err_q;
  assign eng.eng_valid       = valid_q;
  assign eng.eng_proc        = proc_q;
  assign eng.eng_action      = desc_q.action;
  assign eng.eng_ptr         = desc_q.ptr;
  assign eng.eng_copy_start  = desc_q.copy_start;
  assign eng.eng_copy_length = desc_q.copy_length;

endmodule

// File: tb/tb_shm_dma_scheduler.sv
// Scoreboard bench for shm_dma_scheduler: directed requests, engine responder, decoupled monitor.
module tb_shm_dma_scheduler;
  import shm_pkg::*;

  localparam int unsigned P = 4;

  logic                   clock = 1'b0;
  logic                   start;
  logic [P-1:0]           trigger;
  logic [P-1:0]           action;
  logic [SIZE-1:0]        ptr         [P];
  logic [PROCSIZE-1:0]    copy_start  [P];
  logic [PROCSIZE-1:0]    copy_length [P];
  logic [P-1:0]           ack;
  logic [PAGES_COUNT-1:0] ptr_out     [P];
  logic                   proto_err;

  shm_dma_scheduler_if #(.PROC_CNT(P)) eng ();

  shm_dma_scheduler #(.PROC_CNT(P)) dut (
    .clock       (clock),
    .start       (start),
    .trigger     (trigger),
    .action      (action),
    .ptr         (ptr),
    .copy_start  (copy_start),
    .copy_length (copy_length),
    .ack         (ack),
    .ptr_out     (ptr_out),
    .eng         (eng),
    .proto_err   (proto_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int   proc;
    logic act;
    int   ptr;
    int   cs;
    int   cl;
  } exp_desc_t;

  typedef struct {
    int proc;
    bit wr;
    int page;
    int exp_cyc;
  } exp_ack_t;

  exp_desc_t exp_desc[$];
  exp_ack_t  exp_ack[$];

  int errors = 0;
  int checks = 0;

  int bp_cycles = 0;
  int done_lat  = 3;
  int page_val  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    start   = 1'b1;
    trigger = '0;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic issue(input int p, input logic a, input int pt, input int cs, input int cl);
    exp_desc_t d;
    action[p]      = a;
    ptr[p]         = SIZE'(pt);
    copy_start[p]  = PROCSIZE'(cs);
    copy_length[p] = PROCSIZE'(cl);
    d.proc = p; d.act = a; d.ptr = pt; d.cs = cs; d.cl = cl;
    if (cl != 0) exp_desc.push_back(d);
  endtask

  task automatic expect_ack(input int p, input bit wr, input int page, input int ecyc);
    exp_ack_t e;
    e.proc = p; e.wr = wr; e.page = page; e.exp_cyc = ecyc;
    exp_ack.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_desc.size() != 0 || exp_ack.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_in_budget", int'(n < budget), 1);
    tick();
    tick();
  endtask

  // Engine model: accepts after bp_cycles of stall, pulses done done_lat cycles later
  initial begin
    int wait_n   = 0;
    int done_cnt = 0;
    eng.eng_ready = 1'b0;
    eng.eng_done  = 1'b0;
    eng.eng_page  = '0;
    forever begin
      @(posedge clock);
      #2;
      eng.eng_done = 1'b0;
      if (start) begin
        eng.eng_ready = 1'b0;
        wait_n        = 0;
        done_cnt      = 0;
      end else begin
        if (done_cnt == 1) begin
          eng.eng_done = 1'b1;
          eng.eng_page = PAGES_COUNT'(page_val);
        end
        if (done_cnt > 0) done_cnt--;
        if (eng.eng_ready) begin
          eng.eng_ready = 1'b0;
          wait_n        = 0;
          done_cnt      = done_lat;
        end else if (eng.eng_valid) begin
          if (wait_n >= bp_cycles) eng.eng_ready = 1'b1;
          else wait_n++;
        end
      end
    end
  end

  // Monitor: compares presented descriptors and ack toggles against the queues
  initial begin
    logic [P-1:0] ack_prev = '0;
    bit           resync   = 1'b1;
    int           done_cyc = 0;
    exp_desc_t    d;
    exp_ack_t     e;
    int           diff;
    forever begin
      @(negedge clock);
      if (start) begin
        resync = 1'b1;
        continue;
      end
      if (resync) begin
        ack_prev = ack;
        resync   = 1'b0;
        continue;
      end
      if (eng.eng_done) done_cyc = cyc;
      if (eng.eng_valid) begin
        if (exp_desc.size() == 0) begin
          chk("unexpected_desc", 1, 0);
        end else begin
          d = exp_desc[0];
          chk("desc_proc",   int'(eng.eng_proc),        d.proc);
          chk("desc_action", int'(eng.eng_action),      int'(d.act));
          chk("desc_ptr",    int'(eng.eng_ptr),         d.ptr);
          chk("desc_cstart", int'(eng.eng_copy_start),  d.cs);
          chk("desc_clen",   int'(eng.eng_copy_length), d.cl);
          if (eng.eng_ready) void'(exp_desc.pop_front());
        end
      end
      if (ack != ack_prev) begin
        diff     = int'(ack ^ ack_prev);
        ack_prev = ack;
        if (exp_ack.size() == 0) begin
          chk("unexpected_ack", diff, 0);
        end else begin
          e = exp_ack.pop_front();
          chk("ack_which", diff, 1 << e.proc);
          chk("ack_latency", cyc, (e.exp_cyc >= 0) ? e.exp_cyc : done_cyc + 2);
          if (e.wr) chk("ack_ptr_out", int'(ptr_out[e.proc]), e.page);
        end
      end
    end
  end

  initial begin
    start   = 1'b1;
    trigger = '0;
    action  = '0;
    for (int i = 0; i < int'(P); i++) begin
      ptr[i] = '0; copy_start[i] = '0; copy_length[i] = '0;
    end
    tick();
    do_reset();

    chk("rst_valid", int'(eng.eng_valid), 0);
    chk("rst_ack",   int'(ack),           0);
    chk("rst_err",   int'(proto_err),     0);
    chk("rst_proc",  int'(eng.eng_proc),  0);
    for (int i = 0; i < int'(P); i++) chk("rst_ptr_out", int'(ptr_out[i]), 0);

    // Single WRITE from proc2
    bp_cycles = 0; done_lat = 6; page_val = 1;
    issue(2, WRITE, 5, 3, 4);
    expect_ack(2, 1'b1, 1, -1);
    trigger[2] = ~trigger[2];
    tick();
    chk("t1_valid_next_cycle", int'(eng.eng_valid), 1);
    drain(200);
    chk("t1_ack2",     int'(ack[2]),     1);
    chk("t1_ptr_out2", int'(ptr_out[2]), 1);

    // All four toggle together: grants 0,1,2,3
    do_reset();
    done_lat = 3; page_val = 3;
    for (int i = 0; i < int'(P); i++) begin
      issue(i, logic'(i % 2), 8 + i, i, i + 1);
      expect_ack(i, bit'(i % 2), 3, -1);
    end
    trigger = ~trigger;
    drain(400);
    chk("t2_acks",     int'(ack),        15);
    chk("t2_ptr_out0", int'(ptr_out[0]), 0);
    chk("t2_ptr_out3", int'(ptr_out[3]), 3);

    // Backpressure with inputs changing mid-stall
    bp_cycles = 5; done_lat = 2; page_val = 2;
    issue(3, WRITE, 10, 2, 7);
    expect_ack(3, 1'b1, 2, -1);
    trigger[3] = ~trigger[3];
    tick();
    tick();
    ptr[3]         = SIZE'(15);
    copy_length[3] = PROCSIZE'(1);
    drain(200);
    chk("t3_ptr_held",  int'(eng.eng_ptr),         10);
    chk("t3_clen_held", int'(eng.eng_copy_length), 7);
    bp_cycles = 0;

    // Zero-length READ: ack two cycles after the toggle, engine never sees it
    issue(1, READ, 0, 2, 0);
    expect_ack(1, 1'b0, 0, cyc + 2);
    trigger[1] = ~trigger[1];
    tick();
    chk("t4_no_valid_n1", int'(eng.eng_valid), 0);
    tick();
    chk("t4_no_valid_n2", int'(eng.eng_valid), 0);
    drain(100);
    chk("t4_no_err", int'(proto_err), 0);

    // Re-toggle while in service: flagged, then re-granted after the ack
    done_lat = 6; page_val = 2;
    issue(0, WRITE, 4, 1, 2);
    issue(0, WRITE, 4, 1, 2);
    expect_ack(0, 1'b1, 2, -1);
    expect_ack(0, 1'b1, 2, -1);
    trigger[0] = ~trigger[0];
    tick(); tick(); tick();
    trigger[0] = ~trigger[0];
    tick(); tick();
    chk("t5_err_set", int'(proto_err), 1);
    drain(200);
    chk("t5_err_sticky", int'(proto_err), 1);
    chk("t5_ptr_out0",   int'(ptr_out[0]), 2);

    // Reset while BUSY, then a normal request
    done_lat = 10;
    issue(2, READ, 6, 0, 3);
    trigger[2] = ~trigger[2];
    tick(); tick(); tick();
    do_reset();
    chk("t6_valid",    int'(eng.eng_valid), 0);
    chk("t6_ack",      int'(ack),           0);
    chk("t6_err",      int'(proto_err),     0);
    chk("t6_ptr_out0", int'(ptr_out[0]),    0);
    done_lat = 3; page_val = 1;
    issue(1, WRITE, 9, 5, 2);
    expect_ack(1, 1'b1, 1, -1);
    trigger[1] = 1'b1;
    drain(200);
    chk("t6_ack1",     int'(ack[1]),     1);
    chk("t6_ptr_out1", int'(ptr_out[1]), 1);
    chk("t6_no_err",   int'(proto_err),  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
